// File: rtl/ring_pkg.sv
// Shared definitions for the one-hot ring counter and its receive-side monitor.
package ring_pkg;

    localparam int RING_WIDTH = 4;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } ring_state_e;

endpackage

// File: rtl/ring_monitor_if.sv
// Sample/status bundle between a ring pattern source and ring_monitor.
interface ring_monitor_if #(
    parameter int WIDTH = ring_pkg::RING_WIDTH,
    parameter int REV_W = 8,
    parameter int ERR_W = 8
);
    localparam int POS_W = $clog2(WIDTH);

    logic             en;
    logic [WIDTH-1:0] ring_in;
    logic [POS_W-1:0] pos;
    logic             pos_valid;
    logic             locked;
    logic             err;
    logic             wrap;
    logic [ERR_W-1:0] err_count;
    logic [REV_W-1:0] rev_count;

    modport master (
        output en, ring_in,
        input  pos, pos_valid, locked, err, wrap, err_count, rev_count
    );

    modport slave (
        input  en, ring_in,
        output pos, pos_valid, locked, err, wrap, err_count, rev_count
    );
endinterface

// File: rtl/onehot_to_bin.sv
// Combinational one-hot to binary encoder with an exactly-one-bit-set flag.
module onehot_to_bin #(
    parameter int WIDTH = 4,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] i_vec,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    // NOTE: o_idx gets a default before the loop so no path leaves it unassigned (no latch).
    always_comb begin
        o_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i_vec[i]) o_idx = o_idx | IDX_W'(i);
        end
    end

    assign o_valid = $onehot(i_vec);

endmodule

// File: rtl/ring_monitor.sv
// Checks that each enabled sample is the one-step left rotation of the previous one,
// locks after LOCK_CNT good steps, and reports step errors and full revolutions.
module ring_monitor
    import ring_pkg::*;
#(
    parameter int WIDTH    = RING_WIDTH,
    parameter int LOCK_CNT = 2,
    parameter int REV_W    = 8,
    parameter int ERR_W    = 8
) (
    input logic           clk,
    input logic           reset,
    ring_monitor_if.slave bus
);
    localparam int POS_W  = $clog2(WIDTH);
    localparam int GOOD_W = $clog2(LOCK_CNT + 1);

    ring_state_e       r_state;
    logic [GOOD_W-1:0] r_good_cnt;
    logic [WIDTH-1:0]  r_prev;
    logic              r_prev_valid;
    logic [POS_W-1:0]  r_pos;
    logic              r_pos_valid;
    logic              r_err;
    logic              r_wrap;
    logic [ERR_W-1:0]  r_err_count;
    logic [REV_W-1:0]  r_rev_count;

    logic [POS_W-1:0]  w_idx;
    logic              w_onehot;
    logic [WIDTH-1:0]  w_rotl;
    logic              w_step_ok;

    onehot_to_bin #(.WIDTH(WIDTH), .IDX_W(POS_W)) u_enc (
        .i_vec   (bus.ring_in),
        .o_idx   (w_idx),
        .o_valid (w_onehot)
    );

    assign w_rotl    = {r_prev[WIDTH-2:0], r_prev[WIDTH-1]};
    assign w_step_ok = w_onehot && r_prev_valid && (bus.ring_in == w_rotl);

    // NOTE: all state updates use non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= SEARCH;
            r_good_cnt   <= '0;
            r_prev       <= '0;
            r_prev_valid <= 1'b0;
            r_pos        <= '0;
            r_pos_valid  <= 1'b0;
            r_err        <= 1'b0;
            r_wrap       <= 1'b0;
            r_err_count  <= '0;
            r_rev_count  <= '0;
        end else begin
            r_err  <= 1'b0;
            r_wrap <= 1'b0;
            if (bus.en) begin
                if (w_onehot) r_pos <= w_idx;
                r_pos_valid  <= w_onehot;
                r_prev       <= bus.ring_in;
                r_prev_valid <= w_onehot;
                case (r_state)
                    SEARCH: begin
                        if (!w_step_ok) begin
                            r_good_cnt <= '0;
                        end else if (r_good_cnt == GOOD_W'(LOCK_CNT - 1)) begin
                            r_state    <= LOCKED;
                            r_good_cnt <= '0;
                        end else begin
                            r_good_cnt <= r_good_cnt + 1'b1;
                        end
                    end
                    LOCKED: begin
                        if (w_step_ok) begin
                            // A good step landing on bit 0 can only have come from bit WIDTH-1.
                            if (w_idx == '0) begin
                                r_wrap      <= 1'b1;
                                r_rev_count <= r_rev_count + 1'b1;
                            end
                        end else begin
                            r_err      <= 1'b1;
                            r_state    <= SEARCH;
                            r_good_cnt <= '0;
                            if (r_err_count != '1) r_err_count <= r_err_count + 1'b1;
                        end
                    end
                    default: r_state <= SEARCH;
                endcase
            end
        end
    end

    assign bus.pos       = r_pos;
    assign bus.pos_valid = r_pos_valid;
    assign bus.locked    = (r_state == LOCKED);
    assign bus.err       = r_err;
    assign bus.wrap      = r_wrap;
    assign bus.err_count = r_err_count;
    assign bus.rev_count = r_rev_count;

endmodule

// File: tb/tb_ring_monitor.sv
// Directed plus randomized check of ring_monitor against a rule-level reference model.
module tb_ring_monitor;
    localparam int W     = 4;
    localparam int LOCK  = 2;
    localparam int REV_W = 8;
    localparam int ERR_W = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ring_monitor_if #(.WIDTH(W), .REV_W(REV_W), .ERR_W(ERR_W)) bus ();

    ring_monitor #(.WIDTH(W), .LOCK_CNT(LOCK), .REV_W(REV_W), .ERR_W(ERR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests  = 0;
    int failed = 0;

    // Reference model state, expressed in terms of the observable rules.
    int m_pos, m_pos_valid, m_locked, m_err, m_wrap, m_err_count, m_rev_count;
    int m_good, m_prev, m_prev_valid;

    function automatic int next_of(input int p);
        // Doubling with the top position folding back to position 0.
        return ((p * 2) % (2 ** W)) + (p / (2 ** (W - 1)));
    endfunction

    task automatic model(input bit r, input bit e, input int s);
        int ones, idx;
        bit onehot, step_ok;
        m_err  = 0;
        m_wrap = 0;
        if (r) begin
            m_pos = 0; m_pos_valid = 0; m_locked = 0; m_err_count = 0; m_rev_count = 0;
            m_good = 0; m_prev = 0; m_prev_valid = 0;
            return;
        end
        if (!e) return;
        ones = 0;
        idx  = 0;
        for (int i = 0; i < W; i++) begin
            if (((s >> i) & 1) == 1) begin
                ones++;
                idx = i;
            end
        end
        onehot  = (ones == 1);
        step_ok = onehot && (m_prev_valid != 0) && (s == next_of(m_prev));
        if (onehot) m_pos = idx;
        m_pos_valid = onehot;
        if (m_locked != 0) begin
            if (step_ok) begin
                if (m_prev == 2 ** (W - 1) && s == 1) begin
                    m_wrap = 1;
                    m_rev_count = (m_rev_count + 1) % (2 ** REV_W);
                end
            end else begin
                m_err = 1;
                if (m_err_count < 2 ** ERR_W - 1) m_err_count++;
                m_locked = 0;
                m_good = 0;
            end
        end else if (step_ok) begin
            m_good++;
            if (m_good == LOCK) begin
                m_locked = 1;
                m_good = 0;
            end
        end else begin
            m_good = 0;
        end
        m_prev = s;
        m_prev_valid = onehot;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("pos",       32'(bus.pos),       m_pos);
        chk("pos_valid", 32'(bus.pos_valid), m_pos_valid);
        chk("locked",    32'(bus.locked),    m_locked);
        chk("err",       32'(bus.err),       m_err);
        chk("wrap",      32'(bus.wrap),      m_wrap);
        chk("err_count", 32'(bus.err_count), m_err_count);
        chk("rev_count", 32'(bus.rev_count), m_rev_count);
    endtask

    task automatic step(input bit r, input bit e, input logic [W-1:0] s);
        @(negedge clk);
        reset       = r;
        bus.en      = e;
        bus.ring_in = s;
        @(posedge clk);
        #1;
        model(r, e, int'(s));
        check_all();
    endtask

    int pulses;

    initial begin
        reset = 1'b1;
        bus.en = 1'b1;
        bus.ring_in = '0;

        // Reset state
        step(1, 1, 4'b0000);

        // Lock and wrap
        step(0, 1, 4'b0001);
        step(0, 1, 4'b0010);
        step(0, 1, 4'b0100);
        chk("lock_after_3rd", 32'(bus.locked), 1);
        step(0, 1, 4'b1000);
        chk("no_wrap_early", 32'(bus.wrap), 0);
        step(0, 1, 4'b0001);
        chk("wrap_5th", 32'(bus.wrap), 1);
        chk("rev_one", 32'(bus.rev_count), 1);

        // Step error and relock
        step(0, 1, 4'b0100);
        chk("step_err", 32'(bus.err), 1);
        chk("step_err_cnt", 32'(bus.err_count), 1);
        step(0, 1, 4'b1000);
        chk("err_one_cycle", 32'(bus.err), 0);
        step(0, 1, 4'b0001);
        chk("relock", 32'(bus.locked), 1);

        // Invalid patterns
        step(0, 1, 4'b0010);
        step(0, 1, 4'b0000);
        chk("zero_pos_hold", 32'(bus.pos), 1);
        chk("zero_err", 32'(bus.err), 1);
        step(0, 1, 4'b0110);
        chk("multi_no_err", 32'(bus.err), 0);
        step(0, 1, 4'b0001);
        step(0, 1, 4'b0010);
        step(0, 1, 4'b0100);
        chk("relock_after_invalid", 32'(bus.locked), 1);

        // Enable gating
        for (int i = 0; i < 3; i++) step(0, 0, 4'b1111);
        chk("gated_pos", 32'(bus.pos), 2);
        step(0, 1, 4'b1000);
        chk("gated_resume", 32'(bus.locked), 1);

        // Reset mid-run while locked with two revolutions
        step(0, 1, 4'b0001);
        chk("rev_two", 32'(bus.rev_count), 2);
        step(1, 1, 4'b0010);
        step(0, 1, 4'b0010);
        chk("post_rst_pos", 32'(bus.pos), 1);
        chk("post_rst_err", 32'(bus.err), 0);

        // Error counter saturation: five lock/error cycles
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            step(0, 1, 4'b0001);
            step(0, 1, 4'b0010);
            step(0, 1, 4'b0100);
            step(0, 1, 4'b0001);
            if (bus.err === 1'b1) pulses++;
        end
        chk("sat_pulses", pulses, 5);
        chk("sat_count", 32'(bus.err_count), 3);

        // Randomized traffic: mostly legal rotations with faults, gaps and resets
        for (int n = 0; n < 600; n++) begin
            int r;
            logic [W-1:0] s;
            r = int'($urandom_range(0, 99));
            if (r < 3) begin
                step(1, 1, 4'($urandom_range(0, 15)));
            end else if (r < 13) begin
                step(0, 0, 4'($urandom_range(0, 15)));
            end else if (r < 23) begin
                step(0, 1, 4'($urandom_range(0, 15)));
            end else begin
                if (m_prev_valid != 0) s = 4'(next_of(m_prev));
                else s = 4'(1 << $urandom_range(0, W - 1));
                step(0, 1, s);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
